// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared stage codes and defaults for the MNIST BNN datapath
// Purpose: defines the stage code every datapath block decodes, plus the
//          default widths of the sequencer's watchdog and cycle counter.
// Ports:   none (package).
package bnn_pkg;

  localparam int BNN_TIMEOUT_W = 12;
  localparam int BNN_PERF_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_L1   = 3'd2,
    ST_L2   = 3'd3,
    ST_L3   = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } bnn_stage_t;

  function automatic logic stage_is_busy(input bnn_stage_t s);
    return (s == ST_LOAD) || (s == ST_L1) || (s == ST_L2) || (s == ST_L3);
  endfunction

endpackage

// File: rtl/bnn_stage_timer.sv
// rtl/bnn_stage_timer.sv - per-stage watchdog timer
// Purpose: counts cycles spent in one stage; flags the 2^W-1'th running cycle.
// Ports:   clk     in  clock, rising edge
//          rst_n   in  asynchronous active-low reset
//          clear   in  stage is changing; restart from zero next cycle
//          run     in  count this cycle
//          expired out this is the (2^W-1)'th running cycle of the stage
module bnn_stage_timer #(
  parameter int W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of earlier running cycles in this stage, so the
  // current cycle is number cnt_q+1; expiry is flagged on cycle 2^W-1.
  assign expired = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bnn_sequencer.sv
// rtl/bnn_sequencer.sv - start/busy/done inference controller for the MNIST BNN
// Purpose: steps the datapath IDLE->LOAD->L1->L2->L3->DONE, latches the answer,
//          counts busy cycles of each inference.
// Option:  BNN_SEQ_WATCHDOG_EN builds a per-stage watchdog that traps to ERR.
// Ports:   clk, rst_n (async active-low); start, abort, err_clr requests;
//          load_done, layer1_done, layer2_done, layer3_done stage done levels;
//          answer_in class index; outputs state, busy, result_valid, answer,
//          error, err_stage, perf_cycles (all registered).
module bnn_sequencer
  import bnn_pkg::*;
#(
  parameter int TIMEOUT_W = BNN_TIMEOUT_W,
  parameter int PERF_W    = BNN_PERF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              err_clr,
  input  logic              load_done,
  input  logic              layer1_done,
  input  logic              layer2_done,
  input  logic              layer3_done,
  input  logic [3:0]        answer_in,
  output logic [2:0]        state,
  output logic              busy,
  output logic              result_valid,
  output logic [3:0]        answer,
  output logic              error,
  output logic [2:0]        err_stage,
  output logic [PERF_W-1:0] perf_cycles
);

  bnn_stage_t        state_q, state_d;
  logic              busy_q, busy_d;
  logic              result_valid_q, result_valid_d;
  logic [3:0]        answer_q, answer_d;
  logic              error_q, error_d;
  logic [2:0]        err_stage_q, err_stage_d;
  logic [PERF_W-1:0] cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic [PERF_W-1:0] cnt_inc;
  logic              stage_done;
  logic              capture;
  logic              timeout;

`ifdef BNN_SEQ_WATCHDOG_EN
  bnn_stage_timer #(.W(TIMEOUT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_d != state_q),
    .run     (busy_q),
    .expired (timeout)
  );
`else
  // No watchdog: timeout is constant 0 (the width parameter stays referenced
  // so both builds share one parameter list).
  assign timeout = (TIMEOUT_W < 0);
`endif

  always_comb begin
    // Only the done line belonging to the current stage is honoured.
    case (state_q)
      ST_LOAD: stage_done = load_done;
      ST_L1:   stage_done = layer1_done;
      ST_L2:   stage_done = layer2_done;
      ST_L3:   stage_done = layer3_done;
      default: stage_done = 1'b0;
    endcase

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
      ST_LOAD, ST_L1, ST_L2, ST_L3: begin
        // abort beats done, done beats a same-cycle timeout
        if (abort)           state_d = ST_IDLE;
        else if (stage_done) state_d = bnn_stage_t'(state_q + 3'd1);
        else if (timeout)    state_d = ST_ERR;
      end
      ST_ERR:  if (err_clr) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    capture        = (state_q == ST_L3) && (state_d == ST_DONE);
    busy_d         = stage_is_busy(state_d);
    result_valid_d = (state_d == ST_DONE);
    answer_d       = capture ? answer_in : answer_q;

    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + PERF_W'(1);
    cnt_d   = cnt_q;
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      cnt_d = '0;
    end else if (busy_q) begin
      cnt_d = cnt_inc;
    end
    // The capture includes the final L3 cycle itself.
    perf_d = capture ? cnt_inc : perf_q;

`ifdef BNN_SEQ_WATCHDOG_EN
    error_d     = error_q;
    err_stage_d = err_stage_q;
    if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
      error_d     = 1'b1;
      err_stage_d = state_q;
    end else if ((state_q == ST_ERR) && (state_d != ST_ERR)) begin
      error_d     = 1'b0;
      err_stage_d = 3'd0;
    end
`else
    error_d     = 1'b0;
    err_stage_d = 3'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      answer_q       <= 4'd0;
      error_q        <= 1'b0;
      err_stage_q    <= 3'd0;
      cnt_q          <= '0;
      perf_q         <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      answer_q       <= answer_d;
      error_q        <= error_d;
      err_stage_q    <= err_stage_d;
      cnt_q          <= cnt_d;
      perf_q         <= perf_d;
    end
  end

  assign state        = state_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign answer       = answer_q;
  assign error        = error_q;
  assign err_stage    = err_stage_q;
  assign perf_cycles  = perf_q;

endmodule

// File: doc/bnn_sequencer.md
# bnn_sequencer

Top-level inference controller for the MNIST BNN. It replaces the bare state FSM with a start/busy/done handshake and sequences the datapath through weight/pixel load, layer one, layer two and final layer by broadcasting a 3-bit stage code. It latches the 4-bit answer with a valid flag and counts inference cycles. An optional per-stage watchdog traps a layer that never raises its done.

## Interface
Parameters:
- TIMEOUT_W, 12: width of the per-stage watchdog counter. Timeout fires after 2^TIMEOUT_W − 1 cycles in one stage.
- PERF_W, 16: width of the saturating inference cycle counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an inference.
- abort  in  1  synchronous abort of any running inference.
- err_clr  in  1  clears the error state.
- load_done  in  1  level, from the register bank.
- layer1_done  in  1  level, from layer one.
- layer2_done  in  1  level, from layer two.
- layer3_done  in  1  level, from the final layer.
- answer_in  in  4  class index from the final layer.
- state  out  3  stage code broadcast to all datapath blocks.
- busy  out  1  high in LOAD, L1, L2 and L3.
- result_valid  out  1  answer is valid.
- answer  out  4  latched class index.
- error  out  1  a watchdog timeout occurred.
- err_stage  out  3  stage code at the moment of timeout.
- perf_cycles  out  PERF_W  cycles of the last completed inference.

## Operation
- States and codes: IDLE=0, LOAD=1, L1=2, L2=3, L3=4, DONE=5, ERR=6. Code 7 is unused; if reached, the FSM returns to IDLE.
- Transitions:
  - IDLE → LOAD on start.
  - LOAD → L1 on load_done.
  - L1 → L2 on layer1_done.
  - L2 → L3 on layer2_done.
  - L3 → DONE on layer3_done.
  - DONE → LOAD on start.
  - ERR → IDLE on err_clr.
- Done inputs are honoured only in their matching state. A stale or early done in any other state is ignored.
- Abort has priority over every done input. From LOAD, L1, L2 or L3 it forces IDLE on the next edge, and result_valid stays 0. Abort in IDLE, DONE or ERR is ignored.
- Start outside IDLE or DONE is ignored. start and err_clr together in ERR: err_clr wins, so the next state is IDLE and start is dropped.
- Answer capture: on the L3 → DONE edge, answer ← answer_in, result_valid ← 1, perf_cycles ← the running count.
- result_valid clears on the edge that leaves DONE, on abort, and on reset. The answer register holds its value until the next capture.
- Cycle counter:
  - Cleared on entry to LOAD.
  - Increments once per busy cycle.
  - Saturates at 2^PERF_W − 1 and does not wrap.
- Reset values: state=0, busy=0, result_valid=0, answer=0, error=0, err_stage=0, perf_cycles=0.

## Timing
- All outputs are registered. state changes on the edge after the qualifying input is sampled high.
- Handshake latencies:
  - start sampled at edge N gives state=LOAD and busy=1 after edge N.
  - layer3_done sampled at edge M gives state=DONE and result_valid=1 after edge M.
- Minimum inference is 5 cycles from start to result_valid, if each done is high on the first cycle of its stage.
- busy is a registered decode of the state. It is never high in the same cycle as result_valid.
- Reset asserted mid-inference clears everything immediately; no done input is retained.

## Configuration
- BNN_SEQ_WATCHDOG_EN defined:
  - A stage timer clears on every state change and counts while busy.
  - When the timer reaches 2^TIMEOUT_W − 1 without the stage's done, the next state is ERR, with error=1 and err_stage equal to the stalled stage.
  - A done arriving on the same cycle as the timeout wins, and the FSM advances normally.
- BNN_SEQ_WATCHDOG_EN undefined:
  - The timer is not built.
  - error and err_stage are tied to 0, and ERR is unreachable.
  - An unreached ERR still exits on err_clr.

## Structure
- bnn_pkg holds:
  - typedef enum logic [2:0] bnn_stage_t with the codes above.
  - The localparam defaults for TIMEOUT_W and PERF_W.
  - The other datapath blocks import this package to decode state.
- One sub-module, bnn_stage_timer:
  - Ports: clk, rst_n, clear, run, expired.
  - Instantiated only under BNN_SEQ_WATCHDOG_EN.

## Test plan
- Nominal run: reset, pulse start, raise each done 3 cycles into its stage, answer_in=7 → state visits 1,2,3,4,5; answer=7; result_valid=1; perf_cycles=12.
- Stray dones: layer2_done held high during LOAD and L1 → no skip; L2 is entered only after layer1_done.
- Abort: abort in L2 → IDLE on the next edge; result_valid=0; the previous answer is unchanged.
- Back-to-back runs: start in DONE → state=1 and result_valid=0 on the next edge; the second run captures answer_in=3.
- Watchdog (macro on, TIMEOUT_W=4): L1 with no done for 15 cycles → state=6, error=1, err_stage=2; err_clr → IDLE with error=0. Macro off → the FSM stays in L1 indefinitely.
- Async reset asserted mid-L3 → all outputs zero immediately; no result_valid after release.
